// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the CV32E40P instruction-memory responder.
package cv32e40p_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_e;

endpackage

// File: rtl/cv32e40p_imem_array.sv
// Single-port synchronous instruction RAM: one-cycle read latency, a write
// owns the port for that cycle.
module cv32e40p_imem_array #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [DEPTH];

    // NOTE: no reset on the storage; contents survive rst_n and the block maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/cv32e40p_imem_responder.sv
// OBI-style instruction fetch responder backed by a preloadable RAM.
// Optional wait states per fetch are enabled with CV32E40P_IMEM_WAIT_EN.
module cv32e40p_imem_responder
    import cv32e40p_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_req_i,
    output logic                  instr_gnt_o,
    input  logic [31:0]           instr_addr_i,
    output logic                  instr_rvalid_o,
    output logic [31:0]           instr_rdata_o,
    output logic                  instr_err_o,
    input  logic                  load_we_i,
    input  logic [ADDR_WIDTH-1:0] load_addr_i,
    input  logic [31:0]           load_wdata_i
`ifdef CV32E40P_IMEM_WAIT_EN
    ,
    input  logic [WAIT_CNT_W-1:0] wait_cycles_i
`endif
);

    localparam logic [32:0] WIN_BYTES = 33'(4) << ADDR_WIDTH;

    imem_state_e           state;
    logic [31:0]           offset;
    logic                  in_range;
    logic                  accept;
    logic                  err_pend;
    logic                  err_q;
    logic [31:0]           rdata_q;
    logic [31:0]           mem_rdata;
    logic [31:0]           resp_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
`ifdef CV32E40P_IMEM_WAIT_EN
    logic [WAIT_CNT_W-1:0] wait_cnt;
`endif

    // The lower-bound test keeps a window near the top of the address space
    // from aliasing low addresses through the modulo-2^32 subtraction.
    assign offset   = instr_addr_i - BASE_ADDR;
    assign in_range = (instr_addr_i >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);

`ifdef CV32E40P_IMEM_WAIT_EN
    assign instr_gnt_o = rst_n & instr_req_i & ~load_we_i & (state != WAIT);
`else
    assign instr_gnt_o = rst_n & instr_req_i & ~load_we_i;
`endif
    assign accept   = instr_req_i & instr_gnt_o;
    assign mem_addr = load_we_i ? load_addr_i : offset[ADDR_WIDTH+1:2];

    cv32e40p_imem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (load_we_i),
        .en    (accept),
        .addr  (mem_addr),
        .wdata (load_wdata_i),
        .rdata (mem_rdata)
    );

    // The RAM output only moves on an accept, so it stays valid through WAIT;
    // the held copy covers the cycles between responses.
    assign resp_rdata     = err_pend ? 32'h0 : mem_rdata;
    assign instr_rvalid_o = (state == RESP);
    assign instr_rdata_o  = instr_rvalid_o ? resp_rdata : rdata_q;
    assign instr_err_o    = instr_rvalid_o ? err_pend : err_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            err_pend <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
`ifdef CV32E40P_IMEM_WAIT_EN
            wait_cnt <= '0;
`endif
        end else begin
            if (state == RESP) begin
                rdata_q <= resp_rdata;
                err_q   <= err_pend;
            end
            if (accept) begin
                err_pend <= ~in_range;
`ifdef CV32E40P_IMEM_WAIT_EN
                wait_cnt <= wait_cycles_i;
                state    <= (wait_cycles_i == '0) ? RESP : WAIT;
`else
                state    <= RESP;
`endif
            end else begin
                case (state)
`ifdef CV32E40P_IMEM_WAIT_EN
                    WAIT: begin
                        wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
                        if (wait_cnt == WAIT_CNT_W'(1)) begin
                            state <= RESP;
                        end
                    end
`endif
                    RESP:    state <= IDLE;
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_imem_responder.sv
// Self-checking bench for cv32e40p_imem_responder; wait-state scenarios are
// compiled in with CV32E40P_IMEM_WAIT_EN.
module tb_cv32e40p_imem_responder;

    localparam int DEPTH = 4096;
    localparam logic [31:0] HI_BASE = 32'hFFFF_F000;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        we;
    logic [11:0] la;
    logic [31:0] wd;
    logic        hi_gnt;
    logic        hi_rvalid;
    logic [31:0] hi_rdata;
    logic        hi_err;
`ifdef CV32E40P_IMEM_WAIT_EN
    logic [3:0]  wait_cycles;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] model_mem [DEPTH];

    cv32e40p_imem_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_req_i    (req),
        .instr_gnt_o    (gnt),
        .instr_addr_i   (addr),
        .instr_rvalid_o (rvalid),
        .instr_rdata_o  (rdata),
        .instr_err_o    (err),
        .load_we_i      (we),
        .load_addr_i    (la),
        .load_wdata_i   (wd)
`ifdef CV32E40P_IMEM_WAIT_EN
        ,
        .wait_cycles_i  (wait_cycles)
`endif
    );

    cv32e40p_imem_responder #(.ADDR_WIDTH(12), .BASE_ADDR(HI_BASE)) dut_hi (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_req_i    (req),
        .instr_gnt_o    (hi_gnt),
        .instr_addr_i   (addr),
        .instr_rvalid_o (hi_rvalid),
        .instr_rdata_o  (hi_rdata),
        .instr_err_o    (hi_err),
        .load_we_i      (we),
        .load_addr_i    (la),
        .load_wdata_i   (wd)
`ifdef CV32E40P_IMEM_WAIT_EN
        ,
        .wait_cycles_i  (wait_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Window decode done in 64-bit arithmetic straight from the address map.
    function automatic void model_fetch(input logic [31:0] base, input logic [31:0] a,
                                        output logic [31:0] data, output logic e);
        longint unsigned la64, lb64;
        la64 = 64'(a);
        lb64 = 64'(base);
        if (la64 >= lb64 && la64 < lb64 + 64'(4 * DEPTH)) begin
            e    = 1'b0;
            data = model_mem[int'((la64 - lb64) / 4)];
        end else begin
            e    = 1'b1;
            data = 32'h0;
        end
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int idx, input logic [31:0] data);
        we = 1'b1;
        la = 12'(idx);
        wd = data;
        model_mem[idx] = data;
        next();
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 1'b1;
        addr  = 32'h0;
        we    = 1'b0;
        la    = '0;
        wd    = '0;
`ifdef CV32E40P_IMEM_WAIT_EN
        wait_cycles = 4'd0;
`endif
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (gnt !== 1'b0) $display("FAIL reset_gnt: got %b want 0", gnt); else n_pass++;
        n_checks++;
        if (rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", rvalid); else n_pass++;
        n_checks++;
        if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata); else n_pass++;
        n_checks++;
        if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
        next();
        rst_n = 1'b1;
        req   = 1'b0;
        next();
    endtask

    task automatic test_basic();
        load_word(0, 32'h0000_0013);
        load_word(1, 32'h0010_0093);
        req  = 1'b1;
        addr = 32'h0;
        @(negedge clk);
        n_checks++;
        if (gnt !== 1'b1 || rvalid !== 1'b0)
            $display("FAIL basic_accept0: gnt=%b rvalid=%b want gnt=1 rvalid=0", gnt, rvalid);
        else n_pass++;
        next();
        addr = 32'h4;
        @(negedge clk);
        n_checks++;
        if (gnt !== 1'b1 || rvalid !== 1'b1 || rdata !== 32'h0000_0013 || err !== 1'b0)
            $display("FAIL basic_resp0: gnt=%b rvalid=%b rdata=%h err=%b want 1 1 00000013 0",
                     gnt, rvalid, rdata, err);
        else n_pass++;
        next();
        req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h0010_0093 || err !== 1'b0)
            $display("FAIL basic_resp1: rvalid=%b rdata=%h err=%b want 1 00100093 0", rvalid, rdata, err);
        else n_pass++;
        next();
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b0 || rdata !== 32'h0010_0093)
            $display("FAIL basic_hold: rvalid=%b rdata=%h want 0 00100093", rvalid, rdata);
        else n_pass++;
        next();
    endtask

    task automatic test_misaligned();
        req  = 1'b1;
        addr = 32'h6;
        next();
        req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h0010_0093 || err !== 1'b0)
            $display("FAIL misaligned: rvalid=%b rdata=%h err=%b want 1 00100093 0", rvalid, rdata, err);
        else n_pass++;
        next();
    endtask

    task automatic test_oob();
        logic [31:0] top_word;
        top_word = $urandom;
        load_word(DEPTH - 1, top_word);
        req  = 1'b1;
        addr = 32'h0000_3FFC;
        next();
        req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== top_word || err !== 1'b0)
            $display("FAIL oob_last_word: rvalid=%b rdata=%h err=%b want 1 %h 0", rvalid, rdata, err, top_word);
        else n_pass++;
        next();
        req  = 1'b1;
        addr = 32'h0000_4000;
        next();
        req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h0 || err !== 1'b1)
            $display("FAIL oob_fault: rvalid=%b rdata=%h err=%b want 1 00000000 1", rvalid, rdata, err);
        else n_pass++;
        next();
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b0 || rdata !== 32'h0 || err !== 1'b1)
            $display("FAIL oob_hold: rvalid=%b rdata=%h err=%b want 0 00000000 1", rvalid, rdata, err);
        else n_pass++;
        req  = 1'b1;
        addr = 32'h0;
        next();
        req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h0000_0013 || err !== 1'b0)
            $display("FAIL oob_recover: rvalid=%b rdata=%h err=%b want 1 00000013 0", rvalid, rdata, err);
        else n_pass++;
        next();
    endtask

    task automatic test_collision();
        req  = 1'b1;
        addr = 32'h8;
        we   = 1'b1;
        la   = 12'd2;
        wd   = 32'hDEAD_BEEF;
        model_mem[2] = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++;
        if (gnt !== 1'b0) $display("FAIL collision_gnt: got %b want 0", gnt); else n_pass++;
        next();
        we = 1'b0;
        @(negedge clk);
        n_checks++;
        if (gnt !== 1'b1) $display("FAIL collision_regnt: got %b want 1", gnt); else n_pass++;
        next();
        req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF || err !== 1'b0)
            $display("FAIL collision_read: rvalid=%b rdata=%h err=%b want 1 deadbeef 0", rvalid, rdata, err);
        else n_pass++;
        next();
    endtask

`ifdef CV32E40P_IMEM_WAIT_EN
    task automatic test_wait();
        wait_cycles = 4'd3;
        req  = 1'b1;
        addr = 32'h4;
        @(negedge clk);
        n_checks++;
        if (gnt !== 1'b1) $display("FAIL wait_accept: gnt=%b want 1", gnt); else n_pass++;
        next();
        wait_cycles = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (gnt !== 1'b0 || rvalid !== 1'b0)
                $display("FAIL wait_stall%0d: gnt=%b rvalid=%b want 0 0", i, gnt, rvalid);
            else n_pass++;
            next();
        end
        req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h0010_0093 || err !== 1'b0)
            $display("FAIL wait_resp: rvalid=%b rdata=%h err=%b want 1 00100093 0", rvalid, rdata, err);
        else n_pass++;
        next();
        req  = 1'b1;
        addr = 32'h0;
        next();
        req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== 32'h0000_0013)
            $display("FAIL wait_zero_after: rvalid=%b rdata=%h want 1 00000013", rvalid, rdata);
        else n_pass++;
        next();
    endtask
`endif

    task automatic test_reset_mid();
`ifdef CV32E40P_IMEM_WAIT_EN
        wait_cycles = 4'd2;
`endif
        req  = 1'b1;
        addr = 32'h4;
        @(negedge clk);
        n_checks++;
        if (gnt !== 1'b1) $display("FAIL rstmid_accept: gnt=%b want 1", gnt); else n_pass++;
        next();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b0 || rdata !== 32'h0 || err !== 1'b0 || gnt !== 1'b0)
            $display("FAIL rstmid_outputs: rvalid=%b rdata=%h err=%b gnt=%b want 0 00000000 0 0",
                     rvalid, rdata, err, gnt);
        else n_pass++;
        next();
        rst_n = 1'b1;
        req   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (rvalid !== 1'b0) $display("FAIL rstmid_spurious%0d: rvalid=%b want 0", i, rvalid); else n_pass++;
            next();
        end
`ifdef CV32E40P_IMEM_WAIT_EN
        wait_cycles = 4'd0;
`endif
        req  = 1'b1;
        addr = 32'h4;
        next();
        req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== model_mem[1])
            $display("FAIL rstmid_mem_kept: rvalid=%b rdata=%h want 1 %h", rvalid, rdata, model_mem[1]);
        else n_pass++;
        next();
    endtask

    task automatic test_wrap();
        logic [31:0] probes [2];
        logic [31:0] exp_d, exp_hd;
        logic        exp_e, exp_he;
        probes[0] = 32'h0000_0004;
        probes[1] = HI_BASE + 32'h4;
        for (int i = 0; i < 2; i++) begin
            model_fetch(32'h0, probes[i], exp_d, exp_e);
            model_fetch(HI_BASE, probes[i], exp_hd, exp_he);
            req  = 1'b1;
            addr = probes[i];
            next();
            req = 1'b0;
            @(negedge clk);
            n_checks++;
            if (hi_rvalid !== 1'b1 || hi_err !== exp_he || hi_rdata !== exp_hd)
                $display("FAIL wrap_hi%0d: rvalid=%b err=%b rdata=%h want 1 %b %h",
                         i, hi_rvalid, hi_err, hi_rdata, exp_he, exp_hd);
            else n_pass++;
            n_checks++;
            if (rvalid !== 1'b1 || err !== exp_e || rdata !== exp_d)
                $display("FAIL wrap_lo%0d: rvalid=%b err=%b rdata=%h want 1 %b %h",
                         i, rvalid, err, rdata, exp_e, exp_d);
            else n_pass++;
            next();
        end
    endtask

    // Random traffic against a one-outstanding scoreboard keyed on the due cycle.
    task automatic test_random();
        logic        pend = 1'b0;
        int          pend_due = 0;
        logic [31:0] pend_data = '0;
        logic        pend_err = 1'b0;
        logic        have_last = 1'b0;
        logic [31:0] last_data = '0;
        logic        last_err = 1'b0;
        logic        exp_gnt, exp_rvalid;
        int          n;
        for (int i = 0; i < 64; i++) load_word(i, $urandom);
        for (int c = 0; c < 600; c++) begin
            req = ($urandom_range(0, 9) < 7);
            we  = ($urandom_range(0, 9) == 0);
            la  = 12'($urandom_range(0, 63));
            wd  = $urandom;
            if ($urandom_range(0, 4) == 0) addr = 32'h0000_4000 + ($urandom & 32'h7FFF_FFFF);
            else addr = {22'h0, 8'($urandom_range(0, 63)), 2'($urandom)};
            n = 0;
`ifdef CV32E40P_IMEM_WAIT_EN
            if ($urandom_range(0, 9) < 3) n = $urandom_range(1, 3);
            wait_cycles = 4'(n);
`endif
            exp_gnt    = req && !we && !(pend && c < pend_due);
            exp_rvalid = pend && c == pend_due;
            @(negedge clk);
            n_checks++;
            if (gnt !== exp_gnt) $display("FAIL rand_gnt c=%0d: got %b want %b", c, gnt, exp_gnt); else n_pass++;
            n_checks++;
            if (rvalid !== exp_rvalid) $display("FAIL rand_rvalid c=%0d: got %b want %b", c, rvalid, exp_rvalid);
            else n_pass++;
            if (exp_rvalid) begin
                n_checks++;
                if (rdata !== pend_data || err !== pend_err)
                    $display("FAIL rand_resp c=%0d: rdata=%h err=%b want %h %b", c, rdata, err, pend_data, pend_err);
                else n_pass++;
                last_data = pend_data;
                last_err  = pend_err;
                have_last = 1'b1;
                pend      = 1'b0;
            end else if (have_last) begin
                n_checks++;
                if (rdata !== last_data || err !== last_err)
                    $display("FAIL rand_hold c=%0d: rdata=%h err=%b want %h %b", c, rdata, err, last_data, last_err);
                else n_pass++;
            end
            if (exp_gnt) begin
                model_fetch(32'h0, addr, pend_data, pend_err);
                pend     = 1'b1;
                pend_due = c + 1 + n;
            end
            if (we) model_mem[la] = wd;
            next();
        end
        req = 1'b0;
        we  = 1'b0;
        for (int i = 0; i < 6; i++) next();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_misaligned();
        test_oob();
        test_collision();
`ifdef CV32E40P_IMEM_WAIT_EN
        test_wait();
`endif
        test_reset_mid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cv32e40p_imem_responder.md
CV32E40P_IMEM_RESPONDER -- requirements
Module: cv32e40p_imem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, word-address bits (4096 words, 16 KiB).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte base of the mapped window.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port instr_req_i  input  1  fetch request from IF stage.
REQ-006 SHALL have port instr_gnt_o  output  1  request accepted this cycle.
REQ-007 SHALL have port instr_addr_i  input  32  fetch byte address.
REQ-008 SHALL have port instr_rvalid_o  output  1  response valid, single-cycle pulse per accepted request.
REQ-009 SHALL have port instr_rdata_o  output  32  fetched instruction word.
REQ-010 SHALL have port instr_err_o  output  1  response is an access fault, qualified by rvalid.
REQ-011 SHALL have port load_we_i  input  1  preload write strobe (debug/testbench loader).
REQ-012 SHALL have port load_addr_i  input  ADDR_WIDTH  preload word index.
REQ-013 SHALL have port load_wdata_i  input  32  preload data.
REQ-014 SHALL have port wait_cycles_i  input  4  wait states per fetch; present only with CV32E40P_IMEM_WAIT_EN.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL drive instr_gnt_o = instr_req_i & ~load_we_i & (state != WAIT); load write wins any collision.
REQ-017 SHALL accept on instr_req_i & instr_gnt_o; accepted address used, addr[1:0] ignored (word read).
REQ-018 SHALL, zero wait states, go to RESP after accept and assert instr_rvalid_o exactly 1 cycle after accept.
REQ-019 SHALL support back-to-back fetches in RESP: new accept in same cycle as rvalid, throughput 1 word/cycle.
REQ-020 SHALL, with N>0 wait states, go to WAIT after accept, stay N cycles with gnt low, then RESP; rvalid N+1 cycles after accept.
REQ-021 SHALL sample wait count at accept; changes during WAIT SHALL not affect the pending fetch.
REQ-022 SHALL return RESP -> IDLE when no accept in RESP, RESP -> RESP or WAIT on accept.
REQ-023 SHALL flag out-of-window addresses (addr < BASE_ADDR or addr >= BASE_ADDR + 4*2^ADDR_WIDTH): rvalid with err=1, rdata=0, same latency.
REQ-024 SHALL compute window offset modulo 2^32; BASE_ADDR near 32'hFFFF_FFFF SHALL not wrap into a false hit.
REQ-025 SHALL hold instr_rdata_o/instr_err_o stable until next rvalid; err=0 on every in-range response.
REQ-026 SHALL make a load write visible to any fetch accepted in a later cycle (write-then-read, same word).
REQ-027 SHALL return responses strictly in acceptance order, at most one outstanding.

Reset
REQ-028 SHALL reset state=IDLE, instr_rvalid_o=0, instr_err_o=0, instr_rdata_o=0, wait counter=0; gnt=0 while rst_n low.
REQ-029 SHALL discard a pending fetch when reset asserts mid-WAIT/RESP; no rvalid after release until a new accept.
REQ-030 SHALL not reset memory contents.

Configuration
REQ-031 SHALL, with CV32E40P_IMEM_WAIT_EN defined, include wait_cycles_i, the wait counter and the WAIT state.
REQ-032 SHALL, without CV32E40P_IMEM_WAIT_EN, omit wait_cycles_i and WAIT; fixed 1-cycle latency, gnt = req & ~load_we_i.

Structure
REQ-033 SHALL place the FSM state enum and the wait-count width constant in cv32e40p_pkg.
REQ-034 SHALL instantiate one sub-module cv32e40p_imem_array: single-port synchronous RAM, 1-cycle read, write has port priority.

Verification
REQ-035 Bench SHALL cover: load 0x00000013 at word 0, 0x00100093 at word 1; fetch 0x0, 0x4 back-to-back -> rvalid cycles 1 and 2, rdata 0x00000013, 0x00100093, err=0.
REQ-036 Bench SHALL cover: WAIT_EN, wait_cycles_i=3, fetch 0x4 -> gnt low 3 cycles, rvalid 4 cycles after accept; wait_cycles_i changed to 0 mid-WAIT -> no effect.
REQ-037 Bench SHALL cover: fetch 0x0000_4000 (ADDR_WIDTH=12, BASE 0) -> rvalid, err=1, rdata=0; following fetch 0x0 -> err=0.
REQ-038 Bench SHALL cover: load_we_i and instr_req_i same cycle -> gnt=0; fetch of written word next cycle returns new data.
REQ-039 Bench SHALL cover: rst_n low during WAIT -> rvalid, rdata, err all 0; no spurious rvalid after release.
REQ-040 Bench SHALL cover: fetch 0x6 -> word 1 data returned, err=0.
